// File: rtl/hazard_forward_if.sv
// D-stage hazard query and forwarding data bundle shared between the
// pipeline datapath (master) and the hazard/forwarding unit (slave).
interface hazard_forward_if #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int NRD = 2,
  parameter int TW  = 2
);

  // d_valid qualifies every d_* field in the same cycle. There is no ready
  // signal: the only backpressure is stall, and while stall is high the
  // pipeline must hold F/D unchanged so the same D fields are presented again.
  logic              flush;
  logic              d_valid;
  logic [NRD*AW-1:0] d_ra;
  logic [NRD*TW-1:0] d_tuse;
  logic [NRD-1:0]    d_use;
  logic [AW-1:0]     d_a3;
  logic [TW-1:0]     d_tnew;
  logic              d_md_start;
  logic              d_md_long;
  logic              d_md_use;
  logic [DW-1:0]     wd_e;
  logic [DW-1:0]     wd_m;
  logic [DW-1:0]     wd_w;
  logic [NRD*DW-1:0] d_rf_rd;
  logic [NRD*DW-1:0] e_rd;
  logic [DW-1:0]     m_rd2;

  logic              stall;
  logic              md_busy;
  logic [NRD*DW-1:0] d_fwd;
  logic [NRD*DW-1:0] e_fwd;
  logic [DW-1:0]     m_fwd_rt;

  modport master (
    output flush, d_valid, d_ra, d_tuse, d_use, d_a3, d_tnew,
    output d_md_start, d_md_long, d_md_use,
    output wd_e, wd_m, wd_w, d_rf_rd, e_rd, m_rd2,
    input  stall, md_busy, d_fwd, e_fwd, m_fwd_rt
  );

  modport slave (
    input  flush, d_valid, d_ra, d_tuse, d_use, d_a3, d_tnew,
    input  d_md_start, d_md_long, d_md_use,
    input  wd_e, wd_m, wd_w, d_rf_rd, e_rd, m_rd2,
    output stall, md_busy, d_fwd, e_fwd, m_fwd_rt
  );

endinterface

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for a 5-stage MIPS pipeline, with a
// destination scoreboard for E/M/W and a mult/div busy counter.
module hazard_forward_unit #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int NRD    = 2,
  parameter int TW     = 2,
  parameter int MD_LAT = 5
) (
  input logic             clk,
  input logic             reset_n,
  hazard_forward_if.slave hf
);

  localparam int CW = $clog2(2 * MD_LAT + 1);
  localparam int RT = 1;

  // E record keeps every read address (E-stage forwarding); M keeps only rt.
  logic              e_valid_q, e_valid_d;
  logic [AW-1:0]     e_a3_q,    e_a3_d;
  logic [TW-1:0]     e_tnew_q,  e_tnew_d;
  logic [NRD*AW-1:0] e_ra_q,    e_ra_d;

  logic              m_valid_q, m_valid_d;
  logic [AW-1:0]     m_a3_q,    m_a3_d;
  logic [TW-1:0]     m_tnew_q,  m_tnew_d;
  logic [AW-1:0]     m_rt_q,    m_rt_d;

  logic              w_valid_q, w_valid_d;
  logic [AW-1:0]     w_a3_q,    w_a3_d;
  logic [TW-1:0]     w_tnew_q,  w_tnew_d;

  logic [CW-1:0]     md_cnt_q,  md_cnt_d;

  logic              md_busy;
  logic              md_stall;
  logic              hz_stall;
  logic              stall;
  logic [NRD-1:0]    port_stall;
  logic [NRD*DW-1:0] d_fwd_pk;
  logic [NRD*DW-1:0] e_fwd_pk;
  logic [DW-1:0]     m_fwd_rt;

  function automatic logic rec_match(input logic          v,
                                     input logic [AW-1:0] a3,
                                     input logic [AW-1:0] ra);
    return v && (a3 == ra) && (ra != '0);
  endfunction

  function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  for (genvar gi = 0; gi < NRD; gi++) begin : g_port
    logic [AW-1:0] d_ra;
    logic [AW-1:0] e_ra;
    logic [TW-1:0] tuse;
    logic [TW-1:0] tnew_y;
    logic          d_hit_e, d_hit_m, d_hit_w;
    logic          e_hit_m, e_hit_w;
    logic [DW-1:0] d_fwd_v;
    logic [DW-1:0] e_fwd_v;

    assign d_ra = hf.d_ra[gi*AW +: AW];
    assign e_ra = e_ra_q[gi*AW +: AW];
    assign tuse = hf.d_tuse[gi*TW +: TW];

    assign d_hit_e = rec_match(e_valid_q, e_a3_q, d_ra);
    assign d_hit_m = rec_match(m_valid_q, m_a3_q, d_ra);
    assign d_hit_w = rec_match(w_valid_q, w_a3_q, d_ra);
    assign e_hit_m = rec_match(m_valid_q, m_a3_q, e_ra);
    assign e_hit_w = rec_match(w_valid_q, w_a3_q, e_ra);

    // Only the youngest matching producer decides whether D must wait.
    always_comb begin
      tnew_y = '0;
      if (d_hit_e) begin
        tnew_y = e_tnew_q;
      end else if (d_hit_m) begin
        tnew_y = m_tnew_q;
      end else if (d_hit_w) begin
        tnew_y = w_tnew_q;
      end
    end

    assign port_stall[gi] = hf.d_valid & hf.d_use[gi] &
                            (d_hit_e | d_hit_m | d_hit_w) & (tnew_y > tuse);

    always_comb begin
      d_fwd_v = hf.d_rf_rd[gi*DW +: DW];
      if (d_hit_e && (e_tnew_q == '0)) begin
        d_fwd_v = hf.wd_e;
      end else if (d_hit_m && (m_tnew_q == '0)) begin
        d_fwd_v = hf.wd_m;
      end else if (d_hit_w && (w_tnew_q == '0)) begin
        d_fwd_v = hf.wd_w;
      end
    end

    always_comb begin
      e_fwd_v = hf.e_rd[gi*DW +: DW];
      if (e_hit_m && (m_tnew_q == '0)) begin
        e_fwd_v = hf.wd_m;
      end else if (e_hit_w && (w_tnew_q == '0)) begin
        e_fwd_v = hf.wd_w;
      end
    end

    assign d_fwd_pk[gi*DW +: DW] = d_fwd_v;
    assign e_fwd_pk[gi*DW +: DW] = e_fwd_v;
  end

  always_comb begin
    m_fwd_rt = hf.m_rd2;
    if (rec_match(w_valid_q, w_a3_q, m_rt_q) && (w_tnew_q == '0)) begin
      m_fwd_rt = hf.wd_w;
    end
  end

  assign md_busy  = (md_cnt_q != '0);
  assign md_stall = md_busy & (hf.d_md_use | hf.d_md_start);
  assign hz_stall = |port_stall;
  assign stall    = hz_stall | md_stall;

  assign hf.stall    = stall;
  assign hf.md_busy  = md_busy;
  assign hf.d_fwd    = d_fwd_pk;
  assign hf.e_fwd    = e_fwd_pk;
  assign hf.m_fwd_rt = m_fwd_rt;

  // Flush overrides both the shift and a mult/div start on the same edge.
  always_comb begin
    e_valid_d = 1'b0;
    e_a3_d    = '0;
    e_tnew_d  = '0;
    e_ra_d    = '0;

    m_valid_d = e_valid_q;
    m_a3_d    = e_a3_q;
    m_tnew_d  = dec_sat(e_tnew_q);
    m_rt_d    = e_ra_q[RT*AW +: AW];

    w_valid_d = m_valid_q;
    w_a3_d    = m_a3_q;
    w_tnew_d  = dec_sat(m_tnew_q);

    md_cnt_d  = md_busy ? (md_cnt_q - CW'(1)) : '0;

    if (hf.d_valid && !stall) begin
      e_valid_d = 1'b1;
      e_a3_d    = hf.d_a3;
      e_tnew_d  = hf.d_tnew;
      e_ra_d    = hf.d_ra;
      if (hf.d_md_start) begin
        md_cnt_d = hf.d_md_long ? CW'(2 * MD_LAT) : CW'(MD_LAT);
      end
    end

    if (hf.flush) begin
      e_valid_d = 1'b0;
      e_a3_d    = '0;
      e_tnew_d  = '0;
      e_ra_d    = '0;
      m_valid_d = 1'b0;
      m_a3_d    = '0;
      m_tnew_d  = '0;
      m_rt_d    = '0;
      w_valid_d = 1'b0;
      w_a3_d    = '0;
      w_tnew_d  = '0;
      md_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_valid_q <= 1'b0;
      e_a3_q    <= '0;
      e_tnew_q  <= '0;
      e_ra_q    <= '0;
      m_valid_q <= 1'b0;
      m_a3_q    <= '0;
      m_tnew_q  <= '0;
      m_rt_q    <= '0;
      w_valid_q <= 1'b0;
      w_a3_q    <= '0;
      w_tnew_q  <= '0;
      md_cnt_q  <= '0;
    end else begin
      e_valid_q <= e_valid_d;
      e_a3_q    <= e_a3_d;
      e_tnew_q  <= e_tnew_d;
      e_ra_q    <= e_ra_d;
      m_valid_q <= m_valid_d;
      m_a3_q    <= m_a3_d;
      m_tnew_q  <= m_tnew_d;
      m_rt_q    <= m_rt_d;
      w_valid_q <= w_valid_d;
      w_a3_q    <= w_a3_d;
      w_tnew_q  <= w_tnew_d;
      md_cnt_q  <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed pipeline scenarios
// plus randomized traffic against a position/age based reference model.
module tb_hazard_forward_unit;

  localparam int DW     = 32;
  localparam int AW     = 5;
  localparam int NRD    = 2;
  localparam int TW     = 2;
  localparam int MD_LAT = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  hazard_forward_if #(.DW(DW), .AW(AW), .NRD(NRD), .TW(TW)) hf();

  hazard_forward_unit #(.DW(DW), .AW(AW), .NRD(NRD), .TW(TW), .MD_LAT(MD_LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hf      (hf)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: slot 0 = E, 1 = M, 2 = W. A producer's remaining time is
  // its issue-time tnew minus how many stages it has advanced past E.
  bit mv[3];
  int ma3[3];
  int mtn[3];
  int mra0[3];
  int mra1[3];
  int cyc;
  int md_end;

  function automatic int rem(input int k);
    return (mtn[k] - k > 0) ? (mtn[k] - k) : 0;
  endfunction

  function automatic int youngest(input int ra, input int from);
    for (int k = from; k < 3; k++) begin
      if (mv[k] && ma3[k] == ra && ra != 0) return k;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] stage_wd(input int k);
    if (k == 0) return hf.wd_e;
    if (k == 1) return hf.wd_m;
    return hf.wd_w;
  endfunction

  function automatic bit model_busy();
    return md_end > cyc;
  endfunction

  function automatic bit model_stall();
    bit s;
    s = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      int ra;
      int tu;
      int k;
      ra = int'(hf.d_ra[i*AW +: AW]);
      tu = int'(hf.d_tuse[i*TW +: TW]);
      k  = youngest(ra, 0);
      if (hf.d_valid && hf.d_use[i] && k >= 0 && rem(k) > tu) s = 1'b1;
    end
    if (model_busy() && (hf.d_md_use || hf.d_md_start)) s = 1'b1;
    return s;
  endfunction

  function automatic bit model_d_fwd(input int i, output logic [DW-1:0] v);
    int k;
    k = youngest(int'(hf.d_ra[i*AW +: AW]), 0);
    v = hf.d_rf_rd[i*DW +: DW];
    if (k < 0) return 1'b1;
    v = stage_wd(k);
    return rem(k) == 0;
  endfunction

  function automatic bit model_e_fwd(input int i, output logic [DW-1:0] v);
    int k;
    k = youngest((i == 0) ? mra0[0] : mra1[0], 1);
    v = hf.e_rd[i*DW +: DW];
    if (k < 0) return 1'b1;
    v = stage_wd(k);
    return rem(k) == 0;
  endfunction

  function automatic bit model_m_fwd(output logic [DW-1:0] v);
    int k;
    k = youngest(mra1[1], 2);
    v = hf.m_rd2;
    if (k < 0) return 1'b1;
    v = hf.wd_w;
    return rem(k) == 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mv[k] = 1'b0; ma3[k] = 0; mtn[k] = 0; mra0[k] = 0; mra1[k] = 0;
    end
    md_end = 0;
  endtask

  task automatic model_advance(input bit st);
    if (hf.flush) begin
      model_reset();
    end else begin
      if (hf.d_md_start && hf.d_valid && !st)
        md_end = cyc + 1 + (hf.d_md_long ? 2 * MD_LAT : MD_LAT);
      for (int k = 2; k > 0; k--) begin
        mv[k] = mv[k-1]; ma3[k] = ma3[k-1]; mtn[k] = mtn[k-1];
        mra0[k] = mra0[k-1]; mra1[k] = mra1[k-1];
      end
      if (hf.d_valid && !st) begin
        mv[0]   = 1'b1;
        ma3[0]  = int'(hf.d_a3);
        mtn[0]  = int'(hf.d_tnew);
        mra0[0] = int'(hf.d_ra[AW-1:0]);
        mra1[0] = int'(hf.d_ra[2*AW-1:AW]);
      end else begin
        mv[0] = 1'b0; ma3[0] = 0; mtn[0] = 0; mra0[0] = 0; mra1[0] = 0;
      end
    end
    cyc++;
  endtask

  task automatic tick();
    bit st;
    st = model_stall();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_advance(st);
    #1;
  endtask

  task automatic drive_d(input bit v, input int ra0, input int ra1, input bit [1:0] u,
                         input int tu0, input int tu1, input int a3, input int tn,
                         input bit mds, input bit mdl, input bit mdu);
    hf.d_valid    = v;
    hf.d_ra       = {AW'(ra1), AW'(ra0)};
    hf.d_use      = u;
    hf.d_tuse     = {TW'(tu1), TW'(tu0)};
    hf.d_a3       = AW'(a3);
    hf.d_tnew     = TW'(tn);
    hf.d_md_start = mds;
    hf.d_md_long  = mdl;
    hf.d_md_use   = mdu;
    #1;
  endtask

  task automatic idle(input int n);
    drive_d(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    hf.d_rf_rd = {32'h2222_0002, 32'h1111_0001};
    hf.e_rd    = {32'h4444_0004, 32'h3333_0003};
    hf.m_rd2   = 32'h5555_0005;
    hf.wd_e    = 32'hDEAD_0001;
    hf.wd_m    = 32'hDEAD_0002;
    hf.wd_w    = 32'hDEAD_0003;
    drive_d(1, 3, 4, 2'b11, 0, 0, 3, 2, 1, 0, 1);
    @(posedge clk);
    #1;
    compared++;
    if (hf.stall !== 1'b0) begin mismatched++; $display("FAIL reset_stall got=%b exp=0", hf.stall); end
    compared++;
    if (hf.md_busy !== 1'b0) begin mismatched++; $display("FAIL reset_md_busy got=%b exp=0", hf.md_busy); end
    compared++;
    if (hf.d_fwd !== 64'h2222_0002_1111_0001) begin mismatched++; $display("FAIL reset_d_fwd got=%h exp=%h", hf.d_fwd, 64'h2222_0002_1111_0001); end
    compared++;
    if (hf.e_fwd !== 64'h4444_0004_3333_0003) begin mismatched++; $display("FAIL reset_e_fwd got=%h exp=%h", hf.e_fwd, 64'h4444_0004_3333_0003); end
    compared++;
    if (hf.m_fwd_rt !== 32'h5555_0005) begin mismatched++; $display("FAIL reset_m_fwd got=%h exp=55550005", hf.m_fwd_rt); end
    drive_d(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_load_use();
    idle(3);
    drive_d(1, 0, 0, 2'b00, 0, 0, 2, 2, 0, 0, 0);
    tick();
    drive_d(1, 2, 2, 2'b11, 1, 1, 3, 1, 0, 0, 0);
    compared++;
    if (hf.stall !== 1'b1) begin mismatched++; $display("FAIL lu_stall got=%b exp=1", hf.stall); end
    tick();
    compared++;
    if (hf.stall !== 1'b0) begin mismatched++; $display("FAIL lu_release got=%b exp=0", hf.stall); end
    tick();
    drive_d(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    hf.wd_w = 32'h1234;
    hf.e_rd = {32'hBBBB, 32'hAAAA};
    #1;
    compared++;
    if (hf.e_fwd[31:0] !== 32'h1234) begin mismatched++; $display("FAIL lu_e_fwd0 got=%h exp=1234", hf.e_fwd[31:0]); end
    compared++;
    if (hf.e_fwd[63:32] !== 32'h1234) begin mismatched++; $display("FAIL lu_e_fwd1 got=%h exp=1234", hf.e_fwd[63:32]); end
    tick();
  endtask

  task automatic test_branch();
    idle(3);
    drive_d(1, 0, 0, 2'b00, 0, 0, 5, 1, 0, 0, 0);
    tick();
    drive_d(1, 5, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0);
    compared++;
    if (hf.stall !== 1'b1) begin mismatched++; $display("FAIL br_stall got=%b exp=1", hf.stall); end
    tick();
    hf.wd_m    = 32'h5555;
    hf.d_rf_rd = {32'h0, 32'h0BAD};
    #1;
    compared++;
    if (hf.stall !== 1'b0) begin mismatched++; $display("FAIL br_release got=%b exp=0", hf.stall); end
    compared++;
    if (hf.d_fwd[31:0] !== 32'h5555) begin mismatched++; $display("FAIL br_d_fwd got=%h exp=5555", hf.d_fwd[31:0]); end
    tick();
  endtask

  task automatic test_priority();
    idle(3);
    repeat (3) begin
      drive_d(1, 0, 0, 2'b00, 0, 0, 7, 0, 0, 0, 0);
      tick();
    end
    drive_d(1, 7, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0);
    hf.wd_e = 32'd1;
    hf.wd_m = 32'd2;
    hf.wd_w = 32'd3;
    #1;
    compared++;
    if (hf.stall !== 1'b0) begin mismatched++; $display("FAIL prio_stall got=%b exp=0", hf.stall); end
    compared++;
    if (hf.d_fwd[31:0] !== 32'd1) begin mismatched++; $display("FAIL prio_d_fwd got=%h exp=1", hf.d_fwd[31:0]); end
    tick();
    idle(3);
    drive_d(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive_d(1, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0);
    hf.wd_e    = 32'hFFFF_FFFF;
    hf.d_rf_rd = {32'h22, 32'h11};
    #1;
    compared++;
    if (hf.d_fwd !== {32'h22, 32'h11}) begin mismatched++; $display("FAIL zero_reg got=%h exp=%h", hf.d_fwd, {32'h22, 32'h11}); end
    tick();
  endtask

  task automatic test_mult(input bit long_op, input int exp_n);
    int n;
    idle(3);
    drive_d(1, 0, 0, 2'b00, 0, 0, 0, 0, 1, long_op, 1);
    compared++;
    if (hf.stall !== 1'b0 || hf.md_busy !== 1'b0) begin
      mismatched++; $display("FAIL md_start_idle got=%b%b exp=00", hf.stall, hf.md_busy);
    end
    tick();
    drive_d(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    compared++;
    if (hf.md_busy !== 1'b1) begin mismatched++; $display("FAIL md_busy got=%b exp=1", hf.md_busy); end
    n = 0;
    while (hf.stall === 1'b1 && n < 30) begin
      n++;
      tick();
    end
    compared++;
    if (n != exp_n) begin mismatched++; $display("FAIL md_stall_cycles long=%0d got=%0d exp=%0d", long_op, n, exp_n); end
    compared++;
    if (hf.md_busy !== 1'b0) begin mismatched++; $display("FAIL md_release_busy got=%b exp=0", hf.md_busy); end
    tick();
  endtask

  task automatic test_flush();
    idle(3);
    drive_d(1, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0);
    tick();
    drive_d(1, 0, 0, 2'b00, 0, 0, 2, 2, 0, 0, 0);
    tick();
    drive_d(1, 2, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0);
    hf.d_rf_rd = {32'h7777, 32'h6666};
    hf.e_rd    = {32'h9999, 32'h8888};
    hf.m_rd2   = 32'hAAAA;
    #1;
    compared++;
    if (hf.stall !== 1'b1 || hf.md_busy !== 1'b1) begin
      mismatched++; $display("FAIL fl_pre got=%b%b exp=11", hf.stall, hf.md_busy);
    end
    hf.flush = 1'b1;
    tick();
    hf.flush = 1'b0;
    #1;
    compared++;
    if (hf.stall !== 1'b0 || hf.md_busy !== 1'b0) begin
      mismatched++; $display("FAIL fl_post got=%b%b exp=00", hf.stall, hf.md_busy);
    end
    compared++;
    if (hf.d_fwd !== {32'h7777, 32'h6666} || hf.e_fwd !== {32'h9999, 32'h8888} || hf.m_fwd_rt !== 32'hAAAA) begin
      mismatched++; $display("FAIL fl_pass got=%h/%h/%h exp=pass-through", hf.d_fwd, hf.e_fwd, hf.m_fwd_rt);
    end
    tick();
  endtask

  task automatic test_reset_mid_div();
    idle(3);
    drive_d(1, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1, 1);
    tick();
    idle(3);
    compared++;
    if (hf.md_busy !== 1'b1) begin mismatched++; $display("FAIL rd_busy_before got=%b exp=1", hf.md_busy); end
    reset_n = 1'b0;
    #1;
    compared++;
    if (hf.md_busy !== 1'b0 || hf.stall !== 1'b0) begin
      mismatched++; $display("FAIL rd_abort got=%b%b exp=00", hf.md_busy, hf.stall);
    end
    tick();
    reset_n = 1'b1;
    #1;
    drive_d(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    compared++;
    if (hf.stall !== 1'b0) begin mismatched++; $display("FAIL rd_mfhi_stall got=%b exp=0", hf.stall); end
    tick();
  endtask

  task automatic test_random(input int n);
    logic [DW-1:0] ev;
    bit care;
    for (int c = 0; c < n; c++) begin
      hf.flush   = ($urandom_range(0, 24) == 0);
      hf.wd_e    = $urandom;
      hf.wd_m    = $urandom;
      hf.wd_w    = $urandom;
      hf.d_rf_rd = {$urandom, $urandom};
      hf.e_rd    = {$urandom, $urandom};
      hf.m_rd2   = $urandom;
      drive_d($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
              2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 7), $urandom_range(0, 3),
              $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
      compared++;
      if (hf.stall !== model_stall()) begin mismatched++; $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, hf.stall, model_stall()); end
      compared++;
      if (hf.md_busy !== model_busy()) begin mismatched++; $display("FAIL rnd_md_busy c=%0d got=%b exp=%b", c, hf.md_busy, model_busy()); end
      for (int i = 0; i < NRD; i++) begin
        care = model_d_fwd(i, ev);
        if (care) begin
          compared++;
          if (hf.d_fwd[i*DW +: DW] !== ev) begin mismatched++; $display("FAIL rnd_d_fwd c=%0d p=%0d got=%h exp=%h", c, i, hf.d_fwd[i*DW +: DW], ev); end
        end
        care = model_e_fwd(i, ev);
        if (care) begin
          compared++;
          if (hf.e_fwd[i*DW +: DW] !== ev) begin mismatched++; $display("FAIL rnd_e_fwd c=%0d p=%0d got=%h exp=%h", c, i, hf.e_fwd[i*DW +: DW], ev); end
        end
      end
      care = model_m_fwd(ev);
      if (care) begin
        compared++;
        if (hf.m_fwd_rt !== ev) begin mismatched++; $display("FAIL rnd_m_fwd c=%0d got=%h exp=%h", c, hf.m_fwd_rt, ev); end
      end
      tick();
    end
    hf.flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout compared=%0d", compared);
    $fatal(1);
  end

  initial begin
    cyc = 0;
    model_reset();
    hf.flush = 1'b0;
    test_reset();
    test_load_use();
    test_branch();
    test_priority();
    test_mult(1'b0, MD_LAT);
    test_mult(1'b1, 2 * MD_LAT);
    test_flush();
    test_reset_mid_div();
    test_random(400);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
